arm_dp_controller: RTL
======================

ARM_DP_CONTROLLER -- requirements
Module: arm_dp_controller

Interface
REQ-001 SHALL have port clk, input, 1: system clock; state and flags update on posedge.
REQ-002 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have port IR, input, 32: instruction register from the fetch stage, valid from DECODE onward.
REQ-004 SHALL have port W_IR_valid, input, 1: fetch stage's condition-passed, IR-written indication for the current FETCH.
REQ-005 SHALL have port alu_nzcv, input, 4: ALU result flags {N,Z,C,V}.
REQ-006 SHALL have port shift_carry, input, 1: barrel-shifter carry-out.
REQ-007 SHALL have port write_ir and write_pc, output, 1 each: fetch strobes.
REQ-008 SHALL have port NZCV, output, 4: architectural flags register, fed back to the fetch stage.
REQ-009 SHALL have ports rn_addr, rm_addr, rs_addr and rd_addr, output, 4 each: register-file addresses.
REQ-010 SHALL have ports alu_op, output, 4; shift_type, output, 2; shift_amt, output, 5; and rf_write, output, 1.
REQ-011 SHALL have ports imm_sel, output, 1 (operand B = rotated imm8); rs_sel, output, 1 (shift by Rs[7:0]); and imm32, output, 32.
REQ-012 SHALL have port illegal, output, 1: one-cycle pulse on a non-data-processing instruction.

Function
REQ-013 SHALL implement FSM states FETCH, DECODE, EXECUTE and WRITEBACK.
REQ-014 SHALL make write_ir = write_pc = 1 only in FETCH, decoded from state, so they are stable at the fetch stage's negedge.
REQ-015 FETCH SHALL go to DECODE if W_IR_valid=1; otherwise it SHALL go back to FETCH (condition failed: instruction skipped, PC already advanced).
REQ-016 DECODE SHALL go to EXECUTE if IR[27:26]=00; otherwise it SHALL pulse illegal and go to FETCH with no register or flag writes.
REQ-017 EXECUTE SHALL always go to WRITEBACK, and WRITEBACK SHALL always go to FETCH.
REQ-018 Latency SHALL be 4 cycles per executed instruction and 1 cycle per condition-failed instruction.
REQ-019 SHALL drive decode fields combinationally from IR: rn=IR[19:16], rd=IR[15:12], rm=IR[3:0], rs=IR[11:8], alu_op=IR[24:21], imm_sel=IR[25], rs_sel=~IR[25]&IR[4], shift_type=IR[6:5], shift_amt=IR[11:7].
REQ-020 SHALL compute imm32 as IR[7:0] zero-extended to 32 bits and rotated right by 2*IR[11:8] (rotate amount 0 gives an unrotated value).
REQ-021 When imm_sel=1, the carry used for logical ops SHALL be imm32[31] if rotate amount is nonzero, else the current NZCV C.
REQ-022 SHALL assert rf_write only in WRITEBACK and only for alu_op not in 8..B (TST, TEQ, CMP, CMN).
REQ-023 In WRITEBACK, NZCV SHALL update if IR[20]=1 or alu_op is in 8..B; otherwise it SHALL hold.
REQ-024 Arithmetic ops (2..7, A, B) SHALL load NZCV from alu_nzcv.
REQ-025 Logical ops (0, 1, 8, 9, C..F) SHALL load N and Z from alu_nzcv, C from the shifter/immediate carry, and SHALL hold V.
REQ-026 Outputs SHALL be insensitive to IR changes except in DECODE, EXECUTE and WRITEBACK, during which IR is stable by construction.

Reset
REQ-027 On rst, state SHALL be FETCH, NZCV SHALL be 0000, and illegal SHALL be 0; write_ir and write_pc SHALL be 1 immediately after release.
REQ-028 rst asserted mid-instruction SHALL abort the instruction with no rf_write or NZCV update.

Structure
REQ-029 FSM state encodings, opcode constants (AND..MVN) and flag bit indices (N=3, Z=2, C=1, V=0) SHALL live in shared package arm_pkg.
REQ-030 The immediate rotator SHALL be sub-module imm_rotator (IR[11:0] in, imm32 and carry_valid out).

Verification
REQ-031 ADDS R1,R2,#1 (E2921001), W_IR_valid=1, alu_nzcv=0110 -> states F,D,E,W; rf_write=1 in W only; rd=1; NZCV=0110.
REQ-032 CMP R0,R0 (E1500000), alu_nzcv=0110 -> rf_write stays 0; NZCV=0110.
REQ-033 MOVNE with W_IR_valid=0 -> FETCH repeats; write_pc high 2 consecutive cycles; no rf_write.
REQ-034 ANDS imm 0xFF ror 8 (E21000FF with IR[11:8]=4) -> imm32=FF000000; C=1; V unchanged.
REQ-035 Branch encoding (EA000000) -> illegal pulses 1 cycle in DECODE; back to FETCH; NZCV unchanged.
REQ-036 rst asserted during EXECUTE of ADDS -> NZCV=0000, no rf_write, FETCH on release.

Source files
------------

// File: rtl/arm_dp_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_pkg
// Description : Shared definitions for the ARM data-processing controller:
//               FSM state encoding, data-processing opcodes, flag bit
//               positions and small opcode-classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package arm_pkg;

    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_DECODE    = 2'd1,
        ST_EXECUTE   = 2'd2,
        ST_WRITEBACK = 2'd3
    } state_t;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Compare/test ops (TST, TEQ, CMP, CMN): flags only, no register write.
    function automatic logic is_test_op(input logic [3:0] op);
        return (op[3:2] == 2'b10);
    endfunction

    // Ops whose C and V come straight from the ALU adder.
    function automatic logic is_arith_op(input logic [3:0] op);
        return ((op >= OP_SUB) && (op <= OP_RSC)) || (op == OP_CMP) || (op == OP_CMN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/arm_dp_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : arm_dp_controller_if
// Description : Bundle between the fetch stage / datapath (master) and the
//               data-processing controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface arm_dp_controller_if;
    logic [31:0] IR;
    logic        W_IR_valid;
    logic [3:0]  alu_nzcv;
    logic        shift_carry;

    logic        write_ir;
    logic        write_pc;
    logic [3:0]  NZCV;
    logic [3:0]  rn_addr;
    logic [3:0]  rm_addr;
    logic [3:0]  rs_addr;
    logic [3:0]  rd_addr;
    logic [3:0]  alu_op;
    logic [1:0]  shift_type;
    logic [4:0]  shift_amt;
    logic        rf_write;
    logic        imm_sel;
    logic        rs_sel;
    logic [31:0] imm32;
    logic        illegal;

    modport master (
        output IR, W_IR_valid, alu_nzcv, shift_carry,
        input  write_ir, write_pc, NZCV, rn_addr, rm_addr, rs_addr, rd_addr,
               alu_op, shift_type, shift_amt, rf_write, imm_sel, rs_sel,
               imm32, illegal
    );

    modport slave (
        input  IR, W_IR_valid, alu_nzcv, shift_carry,
        output write_ir, write_pc, NZCV, rn_addr, rm_addr, rs_addr, rd_addr,
               alu_op, shift_type, shift_amt, rf_write, imm_sel, rs_sel,
               imm32, illegal
    );
endinterface
`default_nettype wire

// File: rtl/arm_dp_controller_imm_rotator.sv
`default_nettype none
// ============================================================================
// Module      : imm_rotator
// Description : Expands the 12-bit data-processing immediate field into
//               imm8 rotated right by 2*rot4; carry_valid flags a nonzero
//               rotation (only then does imm32[31] act as shifter carry).
// Revision    : 1.0 - initial release
// ============================================================================
module imm_rotator (
    input  wire logic [11:0] imm12,
    output logic      [31:0] imm32,
    output logic             carry_valid
);
    logic [31:0] w_val;
    logic [4:0]  w_rot;
    logic [5:0]  w_lsh;

    // Rotate-right built from two shifts; a zero rotation yields a 32-bit
    // left shift, which contributes nothing.
    always_comb begin
        w_val       = {24'b0, imm12[7:0]};
        w_rot       = {imm12[11:8], 1'b0};
        w_lsh       = 6'd32 - {1'b0, w_rot};
        imm32       = (w_val >> w_rot) | (w_val << w_lsh);
        carry_valid = |imm12[11:8];
    end
endmodule
`default_nettype wire

// File: rtl/arm_dp_controller.sv
`default_nettype none
// ============================================================================
// Module      : arm_dp_controller
// Description : Multi-cycle controller for ARM data-processing instructions.
//               FETCH -> DECODE -> EXECUTE -> WRITEBACK, owns the NZCV flags
//               and decodes register/ALU/shifter controls from IR.
// Revision    : 1.0 - initial release
// ============================================================================
module arm_dp_controller
    import arm_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst,
    arm_dp_controller_if.slave bus
);
    state_t      r_state;
    logic [3:0]  r_nzcv;

    logic [27:0] w_ir;
    logic [3:0]  w_op;
    logic        w_imm_sel;
    logic [31:0] w_imm32;
    logic        w_carry_valid;
    logic        w_logic_c;
    logic        w_flag_upd;

    // IR is only trusted once past FETCH; masking it there keeps every
    // decoded output quiet while the fetch stage is still changing IR.
    always_comb begin
        w_ir = (r_state == ST_FETCH) ? '0 : bus.IR[27:0];
    end

    imm_rotator u_imm_rotator (
        .imm12       (w_ir[11:0]),
        .imm32       (w_imm32),
        .carry_valid (w_carry_valid)
    );

    // Combinational decode fields and state-derived strobes.
    always_comb begin
        w_op      = w_ir[24:21];
        w_imm_sel = w_ir[25];
        // Logical-op carry: rotated immediate carries out bit 31 only when
        // actually rotated; otherwise C is preserved. Register operands use
        // the barrel shifter's carry.
        w_logic_c  = w_imm_sel ? (w_carry_valid ? w_imm32[31] : r_nzcv[FLAG_C])
                               : bus.shift_carry;
        w_flag_upd = w_ir[20] | is_test_op(w_op);

        bus.rn_addr    = w_ir[19:16];
        bus.rd_addr    = w_ir[15:12];
        bus.rs_addr    = w_ir[11:8];
        bus.rm_addr    = w_ir[3:0];
        bus.alu_op     = w_op;
        bus.imm_sel    = w_imm_sel;
        bus.rs_sel     = ~w_ir[25] & w_ir[4];
        bus.shift_type = w_ir[6:5];
        bus.shift_amt  = w_ir[11:7];
        bus.imm32      = w_imm32;

        bus.write_ir = (r_state == ST_FETCH);
        bus.write_pc = (r_state == ST_FETCH);
        bus.rf_write = (r_state == ST_WRITEBACK) && !is_test_op(w_op);
        bus.illegal  = (r_state == ST_DECODE) && (w_ir[27:26] != 2'b00);
        bus.NZCV     = r_nzcv;
    end

    // Instruction sequencing and architectural flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_nzcv  <= 4'b0000;
        end else begin
            case (r_state)
                ST_FETCH:     r_state <= bus.W_IR_valid ? ST_DECODE : ST_FETCH;
                ST_DECODE:    r_state <= (w_ir[27:26] == 2'b00) ? ST_EXECUTE : ST_FETCH;
                ST_EXECUTE:   r_state <= ST_WRITEBACK;
                ST_WRITEBACK: r_state <= ST_FETCH;
                default:      r_state <= ST_FETCH;
            endcase

            if ((r_state == ST_WRITEBACK) && w_flag_upd) begin
                if (is_arith_op(w_op)) begin
                    r_nzcv <= bus.alu_nzcv;
                end else begin
                    r_nzcv <= {bus.alu_nzcv[FLAG_N], bus.alu_nzcv[FLAG_Z],
                               w_logic_c, r_nzcv[FLAG_V]};
                end
            end
        end
    end
endmodule
`default_nettype wire
